// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port
// that was not served last.
module rr_pick2
   import mem_arbiter_pkg::*;
(
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_grant_i,
   output logic grant_c
);

   always_comb begin
      grant_c = PORT0;
      if (req0_i && req1_i) begin
         grant_c = ~last_grant_i;
      end else if (req1_i) begin
         grant_c = PORT1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises req/ack accesses from two masters onto one synchronous memory port
// and returns read data to the granted master.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 6,
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   output logic                  ack0,
   output logic [DATA_WIDTH-1:0] rdata0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  ack1,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   input  logic [DATA_WIDTH-1:0] mem_in,
   output logic                  busy
);

   localparam int unsigned CNT_W = $clog2(READ_LATENCY + 1);

   state_e                state_q;
   logic                  winner_q;
   logic                  is_write_q;
   logic                  last_grant_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  ack0_q, ack1_q;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;
   logic                  mem_we_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_data_q;
   logic                  busy_q;

   logic                  grant_c;
   logic                  sel_we_c;
   logic [ADDR_WIDTH-1:0] sel_addr_c;
   logic [DATA_WIDTH-1:0] sel_wdata_c;

   rr_pick2 u_pick (
      .req0_i       (req0),
      .req1_i       (req1),
      .last_grant_i (last_grant_q),
      .grant_c      (grant_c)
   );

   // Request fields of whichever port wins this cycle.
   always_comb begin
      sel_we_c    = we0;
      sel_addr_c  = addr0;
      sel_wdata_c = wdata0;
      if (grant_c == PORT1) begin
         sel_we_c    = we1;
         sel_addr_c  = addr1;
         sel_wdata_c = wdata1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         winner_q     <= PORT0;
         is_write_q   <= 1'b0;
         last_grant_q <= PORT1;
         cnt_q        <= '0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         busy_q       <= 1'b0;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req0 || req1) begin
                  winner_q   <= grant_c;
                  is_write_q <= sel_we_c;
                  mem_we_q   <= sel_we_c;
                  mem_addr_q <= sel_addr_c;
                  mem_data_q <= sel_wdata_c;
                  busy_q     <= 1'b1;
                  state_q    <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               mem_we_q <= 1'b0;
               if (is_write_q) begin
                  ack0_q  <= (winner_q == PORT0);
                  ack1_q  <= (winner_q == PORT1);
                  state_q <= ST_RESP;
               end else begin
                  cnt_q   <= CNT_W'(READ_LATENCY - 1);
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // The counter reaches zero on the cycle mem_in carries our word.
               if (cnt_q == '0) begin
                  if (winner_q == PORT0) begin
                     rdata0_q <= mem_in;
                  end else begin
                     rdata1_q <= mem_in;
                  end
                  ack0_q  <= (winner_q == PORT0);
                  ack1_q  <= (winner_q == PORT1);
                  state_q <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_RESP: begin
               last_grant_q <= winner_q;
               busy_q       <= 1'b0;
               state_q      <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign rdata0   = rdata0_q;
   assign rdata1   = rdata1_q;
   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_data = mem_data_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two builds (read latency 1 and 3) each checked every cycle
// against a transaction-timeline model, plus directed latency/data pins.
module tb_mem_arbiter;

   localparam int unsigned AW = 6;
   localparam int unsigned DW = 16;

   int checks   = 0;
   int failures = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pick(input logic r0, input logic r1, input int last);
      if (r0 && r1) return 1 - last;
      return r0 ? 0 : 1;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int unsigned LAT = (g == 0) ? 1 : 3;

      logic          rst = 1'b1;
      logic          req   [2];
      logic          we    [2];
      logic [AW-1:0] addr  [2];
      logic [DW-1:0] wdata [2];
      logic          ack0, ack1, mem_we, busy;
      logic [DW-1:0] rdata0, rdata1, mem_data, mem_in;
      logic [AW-1:0] mem_addr;
      logic          done_l = 1'b0;
      logic          armed  = 1'b0;
      int            grant_log[$];

      mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT)) dut (
         .clk(clk), .rst(rst),
         .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]),
         .ack0(ack0), .rdata0(rdata0),
         .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]),
         .ack1(ack1), .rdata1(rdata1),
         .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
         .mem_in(mem_in), .busy(busy)
      );

      // Synchronous memory with LAT cycles from address to data.
      logic [DW-1:0] mem  [64];
      logic [DW-1:0] pipe [LAT];
      always @(posedge clk) begin
         if (mem_we) mem[mem_addr] <= mem_data;
         pipe[0] <= mem[mem_addr];
         for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
      assign mem_in = pipe[LAT-1];

      // Model: a granted transaction occupies cycles t=1..dur, dur=2 (write) or 2+LAT (read).
      logic          m_act, m_we;
      int            m_t, m_dur, m_win, m_last, nw;
      logic [AW-1:0] m_addr, e_addr;
      logic [DW-1:0] m_wd, e_data;
      logic [DW-1:0] m_rd [2];
      logic [DW-1:0] shadow [64];

      always_comb nw = pick(req[0], req[1], m_last);

      always @(posedge clk or posedge rst) begin
         if (rst) begin
            m_act <= 1'b0; m_t <= 0; m_last <= 1;
            m_rd[0] <= '0; m_rd[1] <= '0;
            e_addr <= '0; e_data <= '0;
         end else if (m_act) begin
            if (m_t == m_dur) begin
               m_act  <= 1'b0;
               m_last <= m_win;
            end else begin
               if (m_t == 1 && m_we) shadow[m_addr] <= m_wd;
               if (m_t + 1 == m_dur && !m_we) m_rd[m_win] <= shadow[m_addr];
               m_t <= m_t + 1;
            end
         end else if (req[0] || req[1]) begin
            m_win  <= nw;
            m_we   <= we[nw];
            m_addr <= addr[nw];
            m_wd   <= wdata[nw];
            e_addr <= addr[nw];
            e_data <= wdata[nw];
            m_dur  <= we[nw] ? 2 : 2 + int'(LAT);
            m_t    <= 1;
            m_act  <= 1'b1;
         end
      end

      task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
         checks++;
         if (act !== exp) begin
            failures++;
            $display("FAIL L=%0d %s: got %0h expected %0h at %0t", LAT, nm, act, exp, $time);
         end
      endtask

      always @(posedge clk) armed <= 1'b1;

      always @(negedge clk) begin
         if (armed) begin
            chk("ack0",     32'(ack0),     32'(m_act && m_t == m_dur && m_win == 0));
            chk("ack1",     32'(ack1),     32'(m_act && m_t == m_dur && m_win == 1));
            chk("busy",     32'(busy),     32'(m_act));
            chk("mem_we",   32'(mem_we),   32'(m_act && m_we && m_t == 1));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_data", 32'(mem_data), 32'(e_data));
            chk("rdata0",   32'(rdata0),   32'(m_rd[0]));
            chk("rdata1",   32'(rdata1),   32'(m_rd[1]));
         end
      end

      task automatic do_txn(input int p, input int pre, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output logic [DW-1:0] rd, output int lat);
         for (int i = 0; i < pre; i++) begin
            @(posedge clk); #1;
         end
         req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
         lat = 0;
         do begin
            @(posedge clk); #1;
            lat++;
         end while (!(p == 0 ? ack0 : ack1) && lat < 80);
         if (lat >= 80) begin
            checks++; failures++;
            $display("FAIL L=%0d ack_timeout port%0d: got no ack expected ack within 80 cycles", LAT, p);
         end
         req[p] = 1'b0;
         rd = (p == 0) ? rdata0 : rdata1;
         grant_log.push_back(p);
      endtask

      task automatic do_reset();
         @(posedge clk); #1; rst = 1'b1;
         @(posedge clk); #1; rst = 1'b0;
      endtask

      initial begin
         logic [DW-1:0] rd0, rd1;
         int lat0, lat1;
         for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
         end
         repeat (2) @(posedge clk);
         #1 rst = 1'b0;
         chk("reset_busy",   32'(busy),   32'h0);
         chk("reset_rdata0", 32'(rdata0), 32'h0);

         // Known contents for every address the bench reads.
         for (int i = 0; i < 8; i++) begin
            do_txn(i % 2, 1, 1'b1, AW'(i), DW'(32'hA000 + i), rd0, lat0);
         end
         do_txn(1, 1, 1'b1, AW'(63), 16'h1234, rd0, lat0);

         // Reset while a read sits in WAIT.
         @(posedge clk); #1;
         req[0] = 1'b1; we[0] = 1'b0; addr[0] = AW'(4);
         @(posedge clk); #1;
         @(posedge clk); #1;
         chk("pre_rst_busy", 32'(busy), 32'h1);
         rst = 1'b1;
         #1;
         chk("rst_mem_we", 32'(mem_we), 32'h0);
         chk("rst_ack0",   32'(ack0),   32'h0);
         chk("rst_busy",   32'(busy),   32'h0);
         @(posedge clk); #1;
         rst = 1'b0; req[0] = 1'b0;
         do_txn(0, 1, 1'b0, AW'(4), '0, rd0, lat0);
         chk("reissue_lat",   32'(lat0), 32'(2 + LAT));
         chk("reissue_rdata", 32'(rd0),  32'hA004);

         // Contention right after reset: port 0 first.
         do_reset();
         fork
            do_txn(0, 1, 1'b0, AW'(1), '0, rd0, lat0);
            do_txn(1, 1, 1'b0, AW'(2), '0, rd1, lat1);
         join
         chk("cont_lat0",  32'(lat0), 32'(2 + LAT));
         chk("cont_lat1",  32'(lat1), 32'(5 + 2 * LAT));
         chk("cont_rdata0", 32'(rd0), 32'hA001);
         chk("cont_rdata1", 32'(rd1), 32'hA002);

         // Single write then read-back.
         do_txn(0, 1, 1'b1, AW'(5), 16'hBEEF, rd0, lat0);
         chk("wr_lat", 32'(lat0), 32'd2);
         do_txn(0, 1, 1'b0, AW'(5), '0, rd0, lat0);
         chk("rd_lat",   32'(lat0), 32'(2 + LAT));
         chk("rd_rdata", 32'(rd0),  32'hBEEF);

         // Port-1 read of the top address leaves rdata0 alone.
         do_txn(1, 1, 1'b0, AW'(63), '0, rd1, lat1);
         chk("p1_lat",    32'(lat1),   32'(2 + LAT));
         chk("p1_rdata1", 32'(rd1),    32'h1234);
         chk("p1_rdata0", 32'(rdata0), 32'hBEEF);

         // Late arrival while port 0 is in ACCESS.
         fork
            do_txn(0, 1, 1'b0, AW'(3), '0, rd0, lat0);
            do_txn(1, 2, 1'b0, AW'(6), '0, rd1, lat1);
         join
         chk("late_lat0", 32'(lat0), 32'(2 + LAT));
         chk("late_lat1", 32'(lat1), 32'(4 + 2 * LAT));
         chk("late_rd1",  32'(rd1),  32'hA006);

         // Saturation: both ports re-request immediately, grants must alternate.
         grant_log.delete();
         fork
            for (int i = 0; i < 4; i++) do_txn(0, 1, 1'(i % 2), AW'(i), DW'($urandom), rd0, lat0);
            for (int i = 0; i < 4; i++) do_txn(1, 1, 1'(i % 2), AW'(i + 4), DW'($urandom), rd1, lat1);
         join
         chk("sat_count", 32'(grant_log.size()), 32'd8);
         for (int i = 0; i < grant_log.size(); i++) begin
            chk($sformatf("sat_order%0d", i), 32'(grant_log[i]), 32'(i % 2));
         end

         // Random traffic.
         fork
            for (int i = 0; i < 30; i++)
               do_txn(0, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                      AW'($urandom_range(0, 7)), DW'($urandom), rd0, lat0);
            for (int i = 0; i < 30; i++)
               do_txn(1, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
                      AW'($urandom_range(0, 7)), DW'($urandom), rd1, lat1);
         join
         repeat (4) @(posedge clk);
         done_l = 1'b1;
      end
   end

   initial begin
      int cyc = 0;
      while (!(g_inst[0].done_l && g_inst[1].done_l) && cyc < 60000) begin
         @(posedge clk);
         cyc++;
      end
      if (cyc >= 60000) begin
         checks++; failures++;
         $display("FAIL global_timeout: got unfinished sequence expected completion within 60000 cycles");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
